// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: keeps at most one memory request in flight and hands each fetched word to decode.
// Define YSYX_22040088_IFU_MISALIGN_CHECK_EN to trap misaligned redirect targets in a FAULT state.
module ysyx_22040088_ifu (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault
);
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t      state, state_n;
  logic [63:0] pc, pc_n, redir_target, inst_pc_q;
  logic        kill, kill_n, capture;

`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  assign redir_target = redirect_pc;
`else
  logic unused_redir_bits;
  assign unused_redir_bits = ^redirect_pc[1:0];
  assign redir_target      = {redirect_pc[63:2], 2'b00};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst      <= 32'h0;
      inst_pc_q <= 64'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
      if (capture) begin
        inst      <= imem_resp_data;
        inst_pc_q <= pc;
      end
    end
  end

  // kill marks a request already accepted by memory whose response must be thrown away.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    capture = 1'b0;
    case (state)
      S_REQ: begin
        if (imem_req_ready) state_n = S_WAIT;
        if (redirect_valid) begin
          pc_n = redir_target;
          if (imem_req_ready) kill_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_n   = redir_target;
          kill_n = !imem_resp_valid;
          if (imem_resp_valid) state_n = S_REQ;
        end else if (imem_resp_valid) begin
          kill_n  = 1'b0;
          capture = !kill;
          state_n = kill ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redir_target;
          state_n = S_REQ;
        end else if (inst_ready) begin
          pc_n    = pc + 64'd4;
          state_n = S_REQ;
        end
      end
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
      S_FAULT: begin
        if (imem_resp_valid) kill_n = 1'b0;
        if (redirect_valid) begin
          pc_n    = redir_target;
          state_n = S_REQ;
        end
      end
`endif
      default: state_n = S_REQ;
    endcase
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) state_n = S_FAULT;
`endif
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);

`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  assign fetch_fault = (state == S_FAULT);
  assign inst_pc     = fetch_fault ? pc : inst_pc_q;
`else
  assign fetch_fault = 1'b0;
  assign inst_pc     = inst_pc_q;
`endif

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Bench for ysyx_22040088_ifu: directed scenarios then random traffic against a program-order fetch model
// and a single-slot memory responder whose data is a function of the requested address.
module tb_ysyx_22040088_ifu;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_fault;

  ysyx_22040088_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_pc = RESET_PC;
  logic        exp_fault = 1'b0;
  logic        pend_valid = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  int          pend_delay = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          deliveries = 0;
  int          stall = 0;

  // Instruction memory contents: two fixed words, everything else a hash of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == RESET_PC) return 32'h0000_0093;
    if (a == RESET_PC + 64'd4) return 32'hDEAD_BEEF;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  function automatic logic [63:0] redir_target(input logic [63:0] rpc);
    return MISALIGN_EN ? rpc : {rpc[63:2], 2'b00};
  endfunction

  function automatic logic redir_misaligned(input logic [63:0] rpc);
    return MISALIGN_EN && (rpc[1:0] != 2'b00);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs against the model, advance the model.
  task automatic applyStimulus(input logic rdy, input logic drdy, input logic rv, input logic [63:0] rpc);
    logic resp;
    resp            = pend_valid && (pend_delay == 0);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pend_addr) : 32'h0;
    imem_req_ready  = rdy;
    inst_ready      = drdy;
    redirect_valid  = rv;
    redirect_pc     = rpc;

    checkOutput("fault_flag", fetch_fault, exp_fault);
    checkOutput("req_hold_excl", imem_req_valid & inst_valid, 0);
    if (exp_fault) begin
      checkOutput("fault_quiet", {imem_req_valid, inst_valid}, 0);
      checkOutput("fault_pc", inst_pc, exp_pc);
    end
    if (imem_req_valid) checkOutput("req_addr", imem_req_addr, exp_pc);
    if (inst_valid) begin
      checkOutput("inst_pc", inst_pc, exp_pc);
      checkOutput("inst", inst, mem_word(exp_pc));
    end

    if (resp) pend_valid = 1'b0;
    else if (pend_valid) pend_delay--;
    if (imem_req_valid && rdy) begin
      checkOutput("one_outstanding", pend_valid, 0);
      pend_valid = 1'b1;
      pend_addr  = imem_req_addr;
      pend_delay = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    if (inst_valid && drdy) begin
      deliveries++;
      stall = 0;
    end else begin
      stall++;
    end
    if (rv) begin
      exp_pc    = redir_target(rpc);
      exp_fault = redir_misaligned(rpc);
    end else if (inst_valid && drdy) begin
      exp_pc = exp_pc + 64'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between clock edges; a response still owed by memory stays pending in the responder.
  task automatic do_reset();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    rst = 1'b1;
    #2;
    checkOutput("rst_req_valid", imem_req_valid, 1);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_inst_pc", inst_pc, 0);
    checkOutput("rst_fault", fetch_fault, 0);
    @(negedge clk);
    rst       = 1'b0;
    exp_pc    = RESET_PC;
    exp_fault = 1'b0;
    stall     = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // First fetch and a decode stall of five cycles
    checkOutput("first_req_valid", imem_req_valid, 1);
    checkOutput("first_req_addr", imem_req_addr, RESET_PC);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("wait_no_inst", inst_valid, 0);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("cycle3_inst_valid", inst_valid, 1);
    checkOutput("cycle3_inst", inst, 32'h0000_0093);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", inst_valid, 1);
      checkOutput("hold_no_req", imem_req_valid, 0);
      checkOutput("hold_inst", inst, 32'h0000_0093);
      checkOutput("hold_inst_pc", inst_pc, RESET_PC);
      applyStimulus(1, 0, 0, 64'h0);
    end
    applyStimulus(1, 1, 0, 64'h0);
    checkOutput("next_req_valid", imem_req_valid, 1);
    checkOutput("next_req_addr", imem_req_addr, RESET_PC + 64'd4);

    // Redirect while waiting; the stale word arrives a cycle later
    lat_min = 2; lat_max = 2;
    applyStimulus(1, 0, 0, 64'h0);
    lat_min = 1; lat_max = 1;
    applyStimulus(0, 0, 1, 64'h0000_0000_8000_0100);
    checkOutput("kill_wait", inst_valid, 0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("stale_dropped", inst_valid, 0);
    checkOutput("redir_req_valid", imem_req_valid, 1);
    checkOutput("redir_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("redir_inst_pc", inst_pc, 64'h0000_0000_8000_0100);
    applyStimulus(1, 1, 0, 64'h0);

    // Redirect coinciding with the request handshake
    applyStimulus(1, 0, 1, 64'h0000_0000_8000_0200);
    checkOutput("hs_redir_wait", imem_req_valid, 0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("hs_stale_dropped", inst_valid, 0);
    checkOutput("hs_redir_valid", imem_req_valid, 1);
    checkOutput("hs_redir_addr", imem_req_addr, 64'h0000_0000_8000_0200);
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("hs_inst_pc", inst_pc, 64'h0000_0000_8000_0200);
    applyStimulus(1, 1, 0, 64'h0);

    // Misaligned redirect target
    applyStimulus(0, 0, 1, 64'h0000_0000_8000_0102);
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    checkOutput("fault_set", fetch_fault, 1);
    checkOutput("fault_no_req", imem_req_valid, 0);
    checkOutput("fault_inst_pc", inst_pc, 64'h0000_0000_8000_0102);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("fault_sticky", fetch_fault, 1);
    applyStimulus(1, 0, 1, 64'h0000_0000_8000_0200);
    checkOutput("fault_clear", fetch_fault, 0);
    checkOutput("fault_exit_addr", imem_req_addr, 64'h0000_0000_8000_0200);
`else
    checkOutput("no_fault", fetch_fault, 0);
    checkOutput("align_addr", imem_req_addr, 64'h0000_0000_8000_0100);
`endif
    checkOutput("post_redir_req", imem_req_valid, 1);

    // PC wraps past the top of the address space
    applyStimulus(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("top_inst_valid", inst_valid, 1);
    applyStimulus(1, 1, 0, 64'h0);
    checkOutput("wrap_addr", imem_req_addr, 64'h0);

    // Redirect together with a decode handshake
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(0, 1, 1, 64'h0000_0000_8000_0300);
    checkOutput("hold_redir_addr", imem_req_addr, 64'h0000_0000_8000_0300);
    checkOutput("hold_redir_no_inst", inst_valid, 0);

    // Reset with a request in flight; its late response must be ignored
    applyStimulus(1, 0, 0, 64'h0);
    do_reset();
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("late_resp_ignored", inst_valid, 0);
    checkOutput("reset_refetch", imem_req_addr, RESET_PC);
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("refetch_inst", inst, 32'h0000_0093);
    applyStimulus(1, 1, 0, 64'h0);

    // Random traffic: memory latency 1..3, random ready on both sides, occasional redirects
    lat_min = 1; lat_max = 3;
    deliveries = 0;
    for (int i = 0; i < 2000; i++) begin
      logic        rv;
      logic [63:0] rpc;
      rv  = ($urandom_range(0, 15) == 0);
      rpc = {$urandom, $urandom};
      if (MISALIGN_EN) rpc[1:0] = 2'b00;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv, rpc);
      if (stall > 200) begin
        checkOutput("stall_limit", 64'(stall), 64'd200);
        break;
      end
    end
    checkOutput("progress", 64'(deliveries > 50), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
